// File: rtl/line_collision_monitor_pkg.sv
// Shared game definitions: FSM state encoding, default frame timing and score width.
// Also holds the saturating score increment used by the collision monitor.
package line_collision_monitor_pkg;

    localparam int SCORE_W            = 8;
    localparam int FLASH_FRAMES_DEF   = 16;
    localparam int FRAMES_PER_SEC_DEF = 60;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/line_collision_monitor_if.sv
// Pixel/frame inputs and game-status outputs of the collision monitor.
// master drives the pixel stream and control pulses; slave is the monitor.
interface line_collision_monitor_if #(
    parameter int NUM_LINES = 5
);
    import line_collision_monitor_pkg::*;

    logic                 frame;
    logic                 start_machine;
    logic [NUM_LINES-1:0] line_px;
    logic                 player_px;
    logic                 stop;
    logic                 flash;
    logic                 load_counter;
    logic                 game_over;
    logic [SCORE_W-1:0]   score;

    modport master (
        output frame, start_machine, line_px, player_px,
        input  stop, flash, load_counter, game_over, score
    );

    modport slave (
        input  frame, start_machine, line_px, player_px,
        output stop, flash, load_counter, game_over, score
    );

endinterface

// File: rtl/line_collision_monitor_frame_tick_counter.sv
// Modulo-N counter of frame pulses; wrap is high in the cycle a tick takes it from N-1 back to 0.
// clear has priority over tick.
module frame_tick_counter #(
    parameter int N = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic wrap
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    assign wrap = tick && !clear && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/line_collision_monitor.sv
// Game sequencer: watches player/line pixel overlap, scores seconds survived,
// and flashes the frozen lines after a collision.
module line_collision_monitor
    import line_collision_monitor_pkg::*;
#(
    parameter int NUM_LINES      = 5,
    parameter int FLASH_FRAMES   = FLASH_FRAMES_DEF,
    parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF
) (
    input logic                     clk,
    input logic                     reset,
    line_collision_monitor_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for first start; lines frozen, counters loading
    // RUN   | lines moving, overlap watched, score counting seconds
    // HIT   | collision latched; lines frozen and flashing, score frozen

    logic [1:0]           state;
    logic                 hit_pending;
    logic [NUM_LINES-1:0] line_px;
    logic                 overlap;
    logic                 start_accept;
    logic                 go_hit;
    logic                 sec_tick;
    logic                 sec_wrap;
    logic                 flash_clear;
    logic                 flash_tick;
    logic                 flash_wrap;

    logic                 stop_q;
    logic                 flash_q;
    logic                 load_q;
    logic                 game_over_q;
    logic [SCORE_W-1:0]   score_q;

    assign line_px = bus.line_px;
    assign overlap = bus.player_px & (|line_px);

    always_comb begin
        start_accept = bus.start_machine && (state != ST_RUN);
        // An overlap in the frame cycle itself still counts for the frame ending now.
        go_hit       = (state == ST_RUN) && bus.frame && (hit_pending || overlap);
        sec_tick     = (state == ST_RUN) && bus.frame && !go_hit;
        flash_clear  = start_accept || go_hit;
        flash_tick   = (state == ST_HIT) && bus.frame && !bus.start_machine;
    end

    frame_tick_counter #(.N(FRAMES_PER_SEC)) u_sec_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start_accept),
        .tick  (sec_tick),
        .wrap  (sec_wrap)
    );

    frame_tick_counter #(.N(FLASH_FRAMES)) u_flash_counter (
        .clk   (clk),
        .reset (reset),
        .clear (flash_clear),
        .tick  (flash_tick),
        .wrap  (flash_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            hit_pending <= 1'b0;
            stop_q      <= 1'b0;
            flash_q     <= 1'b1;
            load_q      <= 1'b1;
            game_over_q <= 1'b0;
            score_q     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HIT: begin
                    if (start_accept) begin
                        state       <= ST_RUN;
                        hit_pending <= 1'b0;
                        stop_q      <= 1'b1;
                        flash_q     <= 1'b1;
                        load_q      <= 1'b1;
                        game_over_q <= 1'b0;
                        score_q     <= '0;
                    end else if (flash_wrap) begin
                        flash_q <= ~flash_q;
                    end
                end
                ST_RUN: begin
                    if (bus.frame) begin
                        hit_pending <= 1'b0;
                        load_q      <= 1'b0;
                        if (go_hit) begin
                            state       <= ST_HIT;
                            stop_q      <= 1'b0;
                            flash_q     <= 1'b0;
                            game_over_q <= 1'b1;
                        end else if (sec_wrap) begin
                            score_q <= score_inc(score_q);
                        end
                    end else begin
                        hit_pending <= hit_pending | overlap;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    hit_pending <= 1'b0;
                    stop_q      <= 1'b0;
                    flash_q     <= 1'b1;
                    load_q      <= 1'b1;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stop         = stop_q;
    assign bus.flash        = flash_q;
    assign bus.load_counter = load_q;
    assign bus.game_over    = game_over_q;
    assign bus.score        = score_q;

endmodule

// File: tb/tb_line_collision_monitor.sv
// Scenario bench for line_collision_monitor; expected output words are queued
// when stimulus is driven and popped when the outputs are sampled.
module tb_line_collision_monitor;
    import line_collision_monitor_pkg::*;

    localparam int NL = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    line_collision_monitor_if #(.NUM_LINES(NL)) bus();

    line_collision_monitor #(
        .NUM_LINES      (NL),
        .FLASH_FRAMES   (16),
        .FRAMES_PER_SEC (60)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // {stop, flash, load_counter, game_over, score}
    function automatic logic [11:0] mk(input logic s, input logic f, input logic l,
                                       input logic g, input logic [7:0] sc);
        return {s, f, l, g, sc};
    endfunction

    function automatic logic [11:0] outs();
        return {bus.stop, bus.flash, bus.load_counter, bus.game_over, bus.score};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        bus.frame         = 1'b0;
        bus.start_machine = 1'b0;
        bus.player_px     = 1'b0;
        bus.line_px       = '0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame = 1'b1;
            step();
            step();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        bus.frame = 1'b0; bus.start_machine = 1'b0; bus.player_px = 1'b0; bus.line_px = '0;
        sb.push_back('{"reset_state", mk(0, 1, 1, 0, 8'd0)});
        #12;
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        @(negedge clk);
        reset = 1'b0;
        bus.frame = 1'b1;
        sb.push_back('{"idle_ignores_frame", mk(0, 1, 1, 0, 8'd0)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_score_run();
        exp_t e;
        bus.start_machine = 1'b1;
        sb.push_back('{"start_run", mk(1, 1, 1, 0, 8'd0)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"first_frame_load_low", mk(1, 1, 0, 0, 8'd0)});
        frames(1);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"frame59_no_score", mk(1, 1, 0, 0, 8'd0)});
        frames(58);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"frame60_score1", mk(1, 1, 0, 0, 8'd1)});
        frames(1);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"frame120_score2", mk(1, 1, 0, 0, 8'd2)});
        frames(60);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        bus.start_machine = 1'b1;
        sb.push_back('{"start_in_run_ignored", mk(1, 1, 0, 0, 8'd2)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_hit_mid_frame();
        exp_t e;
        bus.player_px = 1'b1;
        bus.line_px   = 5'b00100;
        sb.push_back('{"overlap_waits_for_frame", mk(1, 1, 0, 0, 8'd2)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        step();
        bus.frame = 1'b1;
        sb.push_back('{"hit_entry", mk(0, 0, 0, 1, 8'd2)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_flash();
        exp_t e;
        for (int k = 1; k <= 64; k++) begin
            sb.push_back('{"flash_seq", mk(0, ((k / 16) % 2) != 0, 0, 1, 8'd2)});
            frames(1);
            e = sb.pop_front(); checks++;
            if (outs() !== e.val) begin errors++; $display("FAIL %s frame %0d got %h expected %h", e.name, k, outs(), e.val); end
        end
        // overlap while in HIT must not be remembered across the restart
        bus.player_px = 1'b1;
        bus.line_px   = 5'b00001;
        step();
        bus.start_machine = 1'b1;
        sb.push_back('{"restart_from_hit", mk(1, 1, 1, 0, 8'd0)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"restart_first_frame", mk(1, 1, 0, 0, 8'd0)});
        frames(1);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_no_overlap();
        exp_t e;
        bus.player_px = 1'b1;
        bus.line_px   = 5'b00000;
        step();
        bus.player_px = 1'b0;
        bus.line_px   = 5'b11111;
        step();
        bus.frame = 1'b1;
        bus.line_px = 5'b11111;
        sb.push_back('{"separate_pixels_no_hit", mk(1, 1, 0, 0, 8'd0)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_same_cycle_overlap();
        exp_t e;
        bus.frame     = 1'b1;
        bus.player_px = 1'b1;
        bus.line_px   = 5'b10000;
        sb.push_back('{"same_cycle_hit", mk(0, 0, 0, 1, 8'd0)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"hit_holds_next_frame", mk(0, 0, 0, 1, 8'd0)});
        frames(1);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_saturation();
        exp_t e;
        bus.start_machine = 1'b1;
        sb.push_back('{"sat_start", mk(1, 1, 1, 0, 8'd0)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"score_254", mk(1, 1, 0, 0, 8'd254)});
        frames(15240);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"score_255", mk(1, 1, 0, 0, 8'd255)});
        frames(60);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"score_saturated", mk(1, 1, 0, 0, 8'd255)});
        frames(60);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        bus.frame     = 1'b1;
        bus.player_px = 1'b1;
        bus.line_px   = 5'b01000;
        sb.push_back('{"hit_before_reset", mk(0, 0, 0, 1, 8'd255)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        sb.push_back('{"async_reset_immediate", mk(0, 1, 1, 0, 8'd0)});
        #1;
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        #1;
        reset = 1'b0;
        step();
        bus.start_machine = 1'b1;
        bus.frame         = 1'b1;
        sb.push_back('{"start_with_frame", mk(1, 1, 1, 0, 8'd0)});
        step();
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"frame_not_counted_59", mk(1, 1, 0, 0, 8'd0)});
        frames(59);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
        sb.push_back('{"frame_not_counted_60", mk(1, 1, 0, 0, 8'd1)});
        frames(1);
        e = sb.pop_front(); checks++;
        if (outs() !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, outs(), e.val); end
    endtask

    initial begin
        test_reset();
        test_score_run();
        test_start_ignored();
        test_hit_mid_frame();
        test_flash();
        test_no_overlap();
        test_same_cycle_overlap();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
